// File: rtl/prog_loader.sv
// Byte-stream program loader: parses SYNC/BASE/LEN/data/CHK frames, writes data
// bytes into memory and releases the CPU from reset once a frame checks good.
module prog_loader #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       cpu_rstn,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT - 1);
    localparam logic [7:0] SYNC = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_LEN, S_DATA, S_CHK, S_DONE, S_ERR
    } state_t;

    state_t        state, state_d;
    logic [7:0]    base, base_d;
    logic [7:0]    len, len_d;
    logic [7:0]    idx, idx_d;
    logic [7:0]    sum, sum_d;
    logic [TW-1:0] idle_cnt, idle_d;
    logic          mem_we_d;
    logic [7:0]    mem_addr_d, mem_wdata_d;
    logic          cpu_rstn_d, busy_d, done_d, err_d;
    logic          accept;

    assign accept = in_valid && in_ready;

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= S_IDLE;
            base      <= 8'h00;
            len       <= 8'h00;
            idx       <= 8'h00;
            sum       <= 8'h00;
            idle_cnt  <= '0;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 8'h00;
            mem_wdata <= 8'h00;
            cpu_rstn  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_d;
            base      <= base_d;
            len       <= len_d;
            idx       <= idx_d;
            sum       <= sum_d;
            idle_cnt  <= idle_d;
            in_ready  <= 1'b1;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            cpu_rstn  <= cpu_rstn_d;
            busy      <= busy_d;
            done      <= done_d;
            err       <= err_d;
        end
    end

    // Frame parser: next state and next register values
    always_comb begin
        state_d     = state;
        base_d      = base;
        len_d       = len;
        idx_d       = idx;
        sum_d       = sum;
        idle_d      = idle_cnt;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        cpu_rstn_d  = cpu_rstn;
        done_d      = done;
        err_d       = err;

        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (accept && in_data == SYNC) begin
                    state_d    = S_ADDR;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    cpu_rstn_d = 1'b0;
                    sum_d      = 8'h00;
                    idx_d      = 8'h00;
                    idle_d     = '0;
                end
            end
            default: begin
                if (accept) begin
                    idle_d = '0;
                    case (state)
                        S_ADDR: begin
                            base_d  = in_data;
                            sum_d   = in_data;
                            state_d = S_LEN;
                        end
                        S_LEN: begin
                            len_d   = in_data;
                            sum_d   = 8'(sum + in_data);
                            state_d = S_DATA;
                        end
                        S_DATA: begin
                            mem_we_d    = 1'b1;
                            mem_addr_d  = 8'(base + idx);
                            mem_wdata_d = in_data;
                            sum_d       = 8'(sum + in_data);
                            idx_d       = 8'(idx + 8'd1);
                            // LEN of 0 wraps to 0xFF here, giving 256 bytes
                            if (idx == 8'(len - 8'd1)) state_d = S_CHK;
                        end
                        default: begin
                            if (8'(sum + in_data) == 8'h00) begin
                                state_d    = S_DONE;
                                done_d     = 1'b1;
                                cpu_rstn_d = 1'b1;
                            end else begin
                                state_d = S_ERR;
                                err_d   = 1'b1;
                            end
                        end
                    endcase
                end else if (!in_valid) begin
                    if (idle_cnt >= IDLE_LAST) begin
                        state_d    = S_ERR;
                        err_d      = 1'b1;
                        cpu_rstn_d = 1'b0;
                        idle_d     = '0;
                    end else begin
                        idle_d = TW'(idle_cnt + TW'(1));
                    end
                end
            end
        endcase

        busy_d = (state_d == S_ADDR) || (state_d == S_LEN) ||
                 (state_d == S_DATA) || (state_d == S_CHK);
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader: frame loads, wrap, checksum,
// timeout, reset mid-frame and a full 256-byte frame behind line noise.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       rstn;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_rstn;
    logic       busy;
    logic       done;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] stim[$];
    logic [7:0] wr_addr[$];
    logic [7:0] wr_data[$];
    logic [7:0] mem_m[256];
    bit         seen[256];
    int         wr_cnt;
    logic       done_pre, busy_pre;

    prog_loader #(.TIMEOUT(255)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_rstn(cpu_rstn), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Write log: captures the strobe that was held during the cycle ending here
    always @(posedge clk) begin
        if (mem_we) begin
            wr_cnt = wr_cnt + 1;
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
            mem_m[mem_addr] = mem_wdata;
            seen[mem_addr]  = 1'b1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic clear_log();
        wr_cnt = 0;
        wr_addr.delete();
        wr_data.delete();
        for (int i = 0; i < 256; i++) begin
            mem_m[i] = 8'h00;
            seen[i]  = 1'b0;
        end
    endtask

    // Back-to-back stream of stim; returns at the negedge after the last accept
    task automatic send_stim();
        for (int i = 0; i < stim.size(); i++) begin
            @(negedge clk);
            if (i == stim.size() - 1) begin
                done_pre = done;
                busy_pre = busy;
            end
            in_valid = 1'b1;
            in_data  = stim[i];
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic test_reset();
        rstn = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge clk);
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        n_checks++; if ({mem_addr, mem_wdata} !== 16'h0000) begin n_fail++; $display("FAIL reset_mem_bus: got %h/%h want 00/00", mem_addr, mem_wdata); end
        n_checks++; if ({cpu_rstn, busy, done, err} !== 4'b0000) begin n_fail++; $display("FAIL reset_status: got cpu_rstn,busy,done,err=%b want 0000", {cpu_rstn, busy, done, err}); end
        rstn = 1'b1;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset: got %b want 1", in_ready); end
        n_checks++; if (cpu_rstn !== 1'b0) begin n_fail++; $display("FAIL cpu_rstn_idle: got %b want 0", cpu_rstn); end
    endtask

    task automatic test_basic();
        clear_log();
        stim = '{8'hA5, 8'h00, 8'h03, 8'hC0, 8'h03, 8'hC1, 8'h79};
        send_stim();
        n_checks++; if (done_pre !== 1'b0 || busy_pre !== 1'b1) begin n_fail++; $display("FAIL basic_before_chk: got done=%b busy=%b want 0/1", done_pre, busy_pre); end
        n_checks++; if ({done, cpu_rstn, err, busy} !== 4'b1100) begin n_fail++; $display("FAIL basic_status: got done,cpu_rstn,err,busy=%b want 1100", {done, cpu_rstn, err, busy}); end
        repeat (3) @(negedge clk);
        n_checks++; if (wr_cnt !== 3) begin n_fail++; $display("FAIL basic_wr_count: got %0d want 3", wr_cnt); end
        n_checks++; if (mem_m[0] !== 8'hC0 || mem_m[1] !== 8'h03 || mem_m[2] !== 8'hC1) begin n_fail++; $display("FAIL basic_mem: got %h %h %h want c0 03 c1", mem_m[0], mem_m[1], mem_m[2]); end
        n_checks++; if (done !== 1'b1 || cpu_rstn !== 1'b1) begin n_fail++; $display("FAIL basic_hold: got done=%b cpu_rstn=%b want 1/1", done, cpu_rstn); end
    endtask

    task automatic test_wrap();
        clear_log();
        stim = '{8'hA5, 8'hFF, 8'h02, 8'h11, 8'h22, 8'hCC};
        send_stim();
        n_checks++; if (done !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL wrap_status: got done=%b err=%b want 1/0", done, err); end
        repeat (2) @(negedge clk);
        n_checks++; if (wr_cnt !== 2) begin n_fail++; $display("FAIL wrap_wr_count: got %0d want 2", wr_cnt); end
        if (wr_cnt == 2) begin
            n_checks++; if (wr_addr[0] !== 8'hFF || wr_data[0] !== 8'h11) begin n_fail++; $display("FAIL wrap_first: got %h=%h want ff=11", wr_addr[0], wr_data[0]); end
            n_checks++; if (wr_addr[1] !== 8'h00 || wr_data[1] !== 8'h22) begin n_fail++; $display("FAIL wrap_second: got %h=%h want 00=22", wr_addr[1], wr_data[1]); end
        end
    endtask

    task automatic test_bad_chk();
        clear_log();
        stim = '{8'hA5, 8'h00, 8'h03, 8'hC0, 8'h03, 8'hC1, 8'h78};
        send_stim();
        n_checks++; if ({err, done, cpu_rstn, busy} !== 4'b1000) begin n_fail++; $display("FAIL badchk_status: got err,done,cpu_rstn,busy=%b want 1000", {err, done, cpu_rstn, busy}); end
        repeat (3) @(negedge clk);
        n_checks++; if (wr_cnt !== 3 || mem_m[2] !== 8'hC1) begin n_fail++; $display("FAIL badchk_writes: got %0d writes mem[02]=%h want 3/c1", wr_cnt, mem_m[2]); end
        n_checks++; if (cpu_rstn !== 1'b0) begin n_fail++; $display("FAIL badchk_cpu_held: got %b want 0", cpu_rstn); end
        stim = '{8'hA5, 8'h00, 8'h03, 8'hC0, 8'h03, 8'hC1, 8'h79};
        send_stim();
        n_checks++; if ({err, done, cpu_rstn} !== 3'b011) begin n_fail++; $display("FAIL badchk_recover: got err,done,cpu_rstn=%b want 011", {err, done, cpu_rstn}); end
    endtask

    task automatic test_timeout();
        clear_log();
        stim = '{8'hA5, 8'h10, 8'h02, 8'h55};
        send_stim();
        n_checks++; if (busy !== 1'b1 || cpu_rstn !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL timeout_start: got busy=%b cpu_rstn=%b done=%b want 1/0/0", busy, cpu_rstn, done); end
        repeat (254) @(negedge clk);
        n_checks++; if (err !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL timeout_early: got err=%b busy=%b after 254 idle want 0/1", err, busy); end
        @(negedge clk);
        n_checks++; if (err !== 1'b1 || cpu_rstn !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL timeout_fire: got err=%b cpu_rstn=%b busy=%b want 1/0/0", err, cpu_rstn, busy); end
        n_checks++; if (wr_cnt !== 1 || mem_m[8'h10] !== 8'h55) begin n_fail++; $display("FAIL timeout_writes: got %0d writes mem[10]=%h want 1/55", wr_cnt, mem_m[8'h10]); end
    endtask

    task automatic test_reset_mid_frame();
        clear_log();
        stim = '{8'hA5, 8'h20, 8'h04, 8'h01, 8'h02};
        send_stim();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if ({in_ready, mem_we, busy, done, err, cpu_rstn} !== 6'b000000 || {mem_addr, mem_wdata} !== 16'h0000) begin n_fail++; $display("FAIL midreset_values: got ready,we,busy,done,err,cpu=%b addr=%h wdata=%h want all 0", {in_ready, mem_we, busy, done, err, cpu_rstn}, mem_addr, mem_wdata); end
        rstn = 1'b1;
        stim = '{8'h03, 8'h04};
        send_stim();
        repeat (3) @(negedge clk);
        n_checks++; if (wr_cnt !== 2) begin n_fail++; $display("FAIL midreset_writes: got %0d want 2", wr_cnt); end
        n_checks++; if ({busy, done, err, cpu_rstn} !== 4'b0000 || {mem_addr, mem_wdata} !== 16'h0000) begin n_fail++; $display("FAIL midreset_idle: got busy,done,err,cpu=%b addr=%h wdata=%h want 0000/00/00", {busy, done, err, cpu_rstn}, mem_addr, mem_wdata); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_noise_full();
        int nseen;
        int bad;
        clear_log();
        stim = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00};
        for (int k = 0; k < 256; k++) stim.push_back(8'(k));
        stim.push_back(8'h80);
        send_stim();
        n_checks++; if ({done, err, cpu_rstn} !== 3'b101) begin n_fail++; $display("FAIL full_status: got done,err,cpu_rstn=%b want 101", {done, err, cpu_rstn}); end
        repeat (3) @(negedge clk);
        n_checks++; if (wr_cnt !== 256) begin n_fail++; $display("FAIL full_wr_count: got %0d want 256", wr_cnt); end
        nseen = 0;
        bad = 0;
        for (int k = 0; k < 256; k++) begin
            if (seen[k]) nseen++;
            if (mem_m[k] !== 8'(k)) bad++;
        end
        n_checks++; if (nseen !== 256) begin n_fail++; $display("FAIL full_coverage: got %0d addresses want 256", nseen); end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL full_data: got %0d wrong bytes want 0", bad); end
    endtask

    initial begin
        clear_log();
        test_reset();
        test_basic();
        test_wrap();
        test_bad_chk();
        test_timeout();
        test_reset_mid_frame();
        test_noise_full();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
